// File: rtl/matmul_mac_sequencer_if.sv
// Control and data port bundle between the MAC sequencer and the operand/result banks.
interface matmul_mac_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 6
);
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [ACC_W-1:0]  c_data;

  // master is the sequencer; slave is the register file / result bank side.
  modport master (
    input  start, abort, a_data, b_data,
    output busy, done, a_addr, b_addr, c_we, c_addr, c_data
  );

  modport slave (
    output start, abort, a_data, b_data,
    input  busy, done, a_addr, b_addr, c_we, c_addr, c_data
  );
endinterface

// File: rtl/matmul_mac_sequencer.sv
// Drives a single multiply-accumulate through (i,j,k) to compute C = A x B for DIM x DIM
// unsigned matrices, writing each C element exactly once.
module matmul_mac_sequencer #(
  parameter int DIM    = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 6
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  matmul_mac_sequencer_if.master  bus
);

  localparam int IDX_W = $clog2(DIM + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);
  localparam logic [IDX_W-1:0] PH_LAST  = IDX_W'(DIM);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]    i_q, i_d;
  logic [IDX_W-1:0]    j_q, j_d;
  logic [IDX_W-1:0]    p_q, p_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ADDR_W-1:0]   c_addr_q, c_addr_d;
  logic [ACC_W-1:0]    c_data_q, c_data_d;
  logic [2*DATA_W-1:0] prod;
  logic                start_ok;
  logic                last_elem;

  function automatic logic [ADDR_W-1:0] flat(input logic [IDX_W-1:0] row,
                                             input logic [IDX_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(DIM) + ADDR_W'(col);
  endfunction

  assign prod      = {{DATA_W{1'b0}}, bus.a_data} * {{DATA_W{1'b0}}, bus.b_data};
  assign start_ok  = bus.start && !bus.abort;
  assign last_elem = (i_q == IDX_LAST) && (j_q == IDX_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: a default for every variable before the case prevents latch inference.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_MAC;
      S_MAC: begin
        if (bus.abort)             state_d = S_IDLE;
        else if (p_q == PH_LAST)   state_d = S_WRITE;
      end
      S_WRITE: begin
        if (bus.abort)       state_d = S_IDLE;
        else if (last_elem)  state_d = S_DONE;
        else                 state_d = S_MAC;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Phase p issues operand k=p and accumulates the pair fetched one cycle earlier.
  always_comb begin
    i_d      = i_q;
    j_d      = j_q;
    p_d      = p_q;
    acc_d    = acc_q;
    c_addr_d = c_addr_q;
    c_data_d = c_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          i_d   = '0;
          j_d   = '0;
          p_d   = '0;
          acc_d = '0;
        end
      end
      S_MAC: begin
        p_d = (p_q == PH_LAST) ? '0 : p_q + 1'b1;
        if (p_q != '0) acc_d = acc_q + ACC_W'(prod);
      end
      S_WRITE: begin
        c_addr_d = flat(i_q, j_q);
        c_data_d = acc_q;
        acc_d    = '0;
        p_d      = '0;
        if (last_elem) begin
          i_d = '0;
          j_d = '0;
        end else if (j_q == IDX_LAST) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      i_q      <= '0;
      j_q      <= '0;
      p_q      <= '0;
      acc_q    <= '0;
      c_addr_q <= '0;
      c_data_q <= '0;
    end else begin
      i_q      <= i_d;
      j_q      <= j_d;
      p_q      <= p_d;
      acc_q    <= acc_d;
      c_addr_q <= c_addr_d;
      c_data_q <= c_data_d;
    end
  end

  // Result port shows the live value during WRITE and holds the last write otherwise.
  always_comb begin
    bus.busy   = (state_q == S_MAC) || (state_q == S_WRITE);
    bus.done   = (state_q == S_DONE);
    bus.c_we   = (state_q == S_WRITE);
    bus.a_addr = '0;
    bus.b_addr = '0;
    if (state_q == S_MAC && p_q != PH_LAST) begin
      bus.a_addr = flat(i_q, p_q);
      bus.b_addr = flat(p_q, j_q);
    end
    bus.c_addr = (state_q == S_WRITE) ? flat(i_q, j_q) : c_addr_q;
    bus.c_data = (state_q == S_WRITE) ? acc_q : c_data_q;
  end

endmodule

// File: tb/tb_matmul_mac_sequencer.sv
// Directed bench for matmul_mac_sequencer: table of matrix cases plus start/abort/reset sequences.
module tb_matmul_mac_sequencer;
  localparam int DIM    = 3;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int ADDR_W = 6;
  localparam int N      = DIM * DIM;
  localparam int DONE_LAT = DIM * DIM * (DIM + 2);
  localparam int WE_LAT   = DIM + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matmul_mac_sequencer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();

  matmul_mac_sequencer #(.DIM(DIM), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
    .ACLK    (clk),
    .ARESETN (rst_n),
    .bus     (bus)
  );

  typedef struct {
    string                   name;
    logic [N-1:0][DATA_W-1:0] a;
    logic [N-1:0][DATA_W-1:0] b;
    logic [N-1:0][ACC_W-1:0]  c;
  } vec_t;

  vec_t vecs[3];

  logic [DATA_W-1:0] mem_a[64];
  logic [DATA_W-1:0] mem_b[64];

  // Operand bank model: one-cycle read latency.
  always @(posedge clk) begin
    bus.a_data <= mem_a[bus.a_addr];
    bus.b_data <= mem_b[bus.b_addr];
  end

  int     cyc = 0;
  int     wr_addr[$];
  longint wr_data[$];
  int     wr_cyc[$];
  int     done_cnt = 0;
  int     done_cyc = 0;
  int     tests = 0;
  int     fails = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.c_we) begin
      wr_addr.push_back(int'(bus.c_addr));
      wr_data.push_back(longint'(bus.c_data));
      wr_cyc.push_back(cyc);
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic load(input int v);
    for (int n = 0; n < 64; n++) begin
      mem_a[n] = '0;
      mem_b[n] = '0;
    end
    for (int n = 0; n < N; n++) begin
      mem_a[n] = vecs[v].a[n];
      mem_b[n] = vecs[v].b[n];
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic pulse_start(output int s);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 300) begin
      step();
      n++;
    end
    if (done_cnt < target) check("done_timeout", done_cnt, target);
  endtask

  task automatic verify_run(input string tag, input int v, input int base, input int s);
    check({tag, "_n_writes"}, wr_addr.size(), base + N);
    if (wr_addr.size() >= base + N) begin
      for (int n = 0; n < N; n++) begin
        check($sformatf("%s_c%0d_addr", tag, n), wr_addr[base+n], n);
        check($sformatf("%s_c%0d_data", tag, n), wr_data[base+n], longint'(vecs[v].c[n]));
      end
      check({tag, "_first_we_lat"}, wr_cyc[base] - s, WE_LAT);
    end
    check({tag, "_done_lat"}, done_cyc - s, DONE_LAT);
  endtask

  initial begin
    int s, s2, t, dsnap;
    int c3[N] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

    vecs[0].name = "ident";
    vecs[1].name = "all255";
    vecs[2].name = "asc_desc";
    for (int n = 0; n < N; n++) begin
      vecs[0].a[n] = ((n / DIM) == (n % DIM)) ? 8'd1 : 8'd0;
      vecs[0].b[n] = DATA_W'(n + 1);
      vecs[0].c[n] = ACC_W'(n + 1);
      vecs[1].a[n] = 8'd255;
      vecs[1].b[n] = 8'd255;
      vecs[1].c[n] = 32'd195075;
      vecs[2].a[n] = DATA_W'(n + 1);
      vecs[2].b[n] = DATA_W'(9 - n);
      vecs[2].c[n] = ACC_W'(c3[n]);
    end

    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) step();
    check("rst_busy",   bus.busy,   0);
    check("rst_done",   bus.done,   0);
    check("rst_c_we",   bus.c_we,   0);
    check("rst_a_addr", bus.a_addr, 0);
    check("rst_b_addr", bus.b_addr, 0);
    check("rst_c_addr", bus.c_addr, 0);
    check("rst_c_data", bus.c_data, 0);
    rst_n = 1'b1;
    step();

    // Table-driven matrix cases.
    for (int v = 0; v < 3; v++) begin
      clear_log();
      load(v);
      t = done_cnt + 1;
      pulse_start(s);
      check({vecs[v].name, "_busy_after_start"}, bus.busy, 1);
      wait_done(t);
      check({vecs[v].name, "_busy_in_done"}, bus.busy, 0);
      verify_run(vecs[v].name, v, 0, s);
      step();
      step();
    end

    // Start during busy and during DONE is ignored; start right after DONE begins a new run.
    clear_log();
    load(2);
    dsnap = done_cnt;
    pulse_start(s);
    repeat (10) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("midrun_start_busy", bus.busy, 1);
    wait_done(dsnap + 1);
    bus.start = 1'b1;
    step();
    check("start_in_done_ignored", bus.busy, 0);
    step();
    bus.start = 1'b0;
    s2 = cyc;
    check("start_after_done_busy", bus.busy, 1);
    check("ignored_done_count", done_cnt - dsnap, 1);
    verify_run("ignore_run1", 2, 0, s);
    wait_done(dsnap + 2);
    verify_run("ignore_run2", 2, N, s2);
    step();

    // Abort during the second WRITE: that write lands, then idle with no done.
    clear_log();
    load(0);
    dsnap = done_cnt;
    pulse_start(s);
    while (cyc < s + WE_LAT + DIM + 2) step();
    check("abort_wr_c_we",   bus.c_we,   1);
    check("abort_wr_c_addr", bus.c_addr, 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    repeat (60) step();
    check("abort_no_done", done_cnt - dsnap, 0);
    check("abort_n_writes", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("abort_last_addr", wr_addr[1], 1);
      check("abort_last_data", wr_data[1], 2);
    end
    clear_log();
    pulse_start(s);
    wait_done(dsnap + 1);
    verify_run("after_abort", 0, 0, s);
    step();

    // Asynchronous reset in the middle of MAC.
    clear_log();
    load(2);
    pulse_start(s);
    repeat (2) step();
    check("pre_rst_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy",   bus.busy,   0);
    check("midrst_c_we",   bus.c_we,   0);
    check("midrst_done",   bus.done,   0);
    check("midrst_a_addr", bus.a_addr, 0);
    check("midrst_b_addr", bus.b_addr, 0);
    check("midrst_c_addr", bus.c_addr, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    clear_log();
    t = done_cnt + 1;
    pulse_start(s);
    wait_done(t);
    verify_run("after_rst", 2, 0, s);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
